fifo_uart_tx: RTL

Drain-side consumer for the button-loaded `fifo`: whenever enabled and the FIFO is non-empty, it pops one word and transmits it as an 8N1 UART frame on a single serial line. It sits between the FIFO read port and the board's UART TX pin, replacing the manual read pushbutton in the demo design. It has one clock domain and no debouncing; all inputs are synchronous except `reset`.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/fifo_uart_tx_if.sv | 11 +
 rtl/uart_baud_gen.sv | 27 ++
 rtl/fifo_uart_tx.sv | 117 +++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: framing constants, default bit period and the TX state encoding.
// The receive side is expected to reuse the same constants.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_FRAME_BITS   = 10;
  localparam int UART_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
    STOP
  } uart_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port as seen by the UART drain: empty flag and data in, pop strobe out.
interface fifo_uart_tx_if #(
  parameter int width = 8
);
  logic             fifo_empty;
  logic [width-1:0] fifo_data;
  logic             fifo_rd;

  modport master (input fifo_empty, input fifo_data, output fifo_rd);
  modport slave  (output fifo_empty, output fifo_data, input fifo_rd);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..clks_per_bit-1, raises tick on the terminal count.
module uart_baud_gen #(
  parameter int clks_per_bit = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  output logic        tick,
  output logic [15:0] count
);

  logic [15:0] count_reg;

  assign count = count_reg;
  assign tick  = (count_reg == 16'(clks_per_bit - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear || tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 16'd1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a FIFO whenever enabled and non-empty, and sends each one as an 8N1 frame.
// tx, fifo_rd and tx_done are registered from the next-state decode, so they align with the state.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int width        = 8,
  parameter int clks_per_bit = UART_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done,
  output logic [15:0]           frames_sent
);

  if (width != UART_DATA_BITS) begin : g_bad_width
    $error("fifo_uart_tx: width must be 8");
  end
  if (clks_per_bit < 2 || clks_per_bit > 65535) begin : g_bad_clks_per_bit
    $error("fifo_uart_tx: clks_per_bit must be in 2..65535");
  end

  uart_state_t      state_reg, state_next;
  logic [width-1:0] shift_reg, shift_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic             tx_reg, tx_next;
  logic             fifo_rd_reg, fifo_rd_next;
  logic             tx_done_reg, tx_done_next;
  logic [15:0]      frames_sent_reg;
  logic             baud_clear;
  logic             baud_tick;
  logic [15:0]      baud_count;

  uart_baud_gen #(
    .clks_per_bit(clks_per_bit)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(baud_clear),
    .tick (baud_tick),
    .count(baud_count)
  );

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx_reg;
    case (state_reg)
      IDLE:  if (enable && !fifo.fifo_empty) state_next = REQ;
      REQ:   state_next = LOAD;
      LOAD: begin
        shift_next = fifo.fifo_data;
        state_next = START;
      end
      START: begin
        if (baud_tick) begin
          state_next   = DATA;
          bit_idx_next = 3'd0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift_next   = shift_reg >> 1;
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) state_next = STOP;
        end
      end
      STOP:  if (baud_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output registers are loaded from the upcoming state so they change on the same edge as it.
  always_comb begin
    tx_next      = 1'b1;
    fifo_rd_next = (state_next == REQ);
    tx_done_next = (state_reg == STOP) && (baud_count == 16'(clks_per_bit - 2));
    baud_clear   = (state_next != state_reg) || (state_reg == IDLE);
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      shift_reg       <= '0;
      bit_idx_reg     <= '0;
      tx_reg          <= 1'b1;
      fifo_rd_reg     <= 1'b0;
      tx_done_reg     <= 1'b0;
      frames_sent_reg <= '0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_idx_reg <= bit_idx_next;
      tx_reg      <= tx_next;
      fifo_rd_reg <= fifo_rd_next;
      tx_done_reg <= tx_done_next;
      if (state_reg == STOP && baud_tick) begin
        frames_sent_reg <= sat_inc16(frames_sent_reg);
      end
    end
  end

  assign fifo.fifo_rd = fifo_rd_reg;
  assign tx           = tx_reg;
  assign tx_done      = tx_done_reg;
  assign busy         = (state_reg != IDLE);
  assign frames_sent  = frames_sent_reg;

endmodule
